// File: rtl/fifo_wr_cnt_pkg.sv
// Shared types and constants for the FIFO write-count monitor.
package fifo_wr_cnt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int DEF_CNT_W  = 32;
   localparam int DEF_DROP_W = 16;

   // Bit positions inside the status readback word.
   localparam int STAT_OVF   = 3;
   localparam int STAT_THR   = 2;
   localparam int STAT_ST_HI = 1;
   localparam int STAT_ST_LO = 0;

endpackage

// File: rtl/fifo_wr_cnt_ctr.sv
// Parameterised up-counter with synchronous clear, saturate-or-wrap at the
// top value, and an all-ones flag for the owner to detect overflow.
module fifo_wr_cnt_ctr #(
   parameter int W   = 32,
   parameter bit SAT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   localparam logic [W-1:0] ONE = W'(1);

   assign at_max = &cnt;

   // Clear wins over increment; at the top value either hold or roll over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !(SAT && at_max))
         cnt <= cnt + ONE;
   end

endmodule

// File: rtl/fifo_wr_cnt_core.sv
// Counts writes accepted by a monitored FIFO and writes dropped while it is
// full, with snapshot capture, sticky overflow and a one-shot threshold irq.
module fifo_wr_cnt_core
   import fifo_wr_cnt_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int DROP_W   = DEF_DROP_W,
   parameter int SAT_MODE = 1
) (
   input  logic              s00_axi_aclk,
   input  logic              s00_axi_aresetn,
   input  logic              fifo_wr_en,
   input  logic              fifo_full,
   input  logic              ctrl_enable,
   input  logic              ctrl_clear,
   input  logic              ctrl_snapshot,
   input  logic [CNT_W-1:0]  threshold,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  snap_cnt,
   output logic [DROP_W-1:0] drop_cnt,
   output logic [3:0]        status,
   output logic              irq
);

   localparam bit SAT = (SAT_MODE != 0);

   state_t state, state_nxt;
   logic   ovf, thresh_hit;
   logic   wr_max, drop_max;
   logic   run, accepted, dropped, ovf_ev, thr_fire;

   assign run      = (state == ST_RUN);
   assign accepted = run & fifo_wr_en & ~fifo_full;
   assign dropped  = run & fifo_wr_en & fifo_full & ~drop_max;
   assign ovf_ev   = accepted & wr_max & ~ctrl_clear;
   // Compare against the registered count, so the hit lands one edge late.
   assign thr_fire = (threshold != '0) && (wr_cnt == threshold) && !thresh_hit;

   fifo_wr_cnt_ctr #(.W(CNT_W), .SAT(SAT)) u_wr_ctr (
      .clk    (s00_axi_aclk),
      .rst_n  (s00_axi_aresetn),
      .inc    (accepted),
      .clr    (ctrl_clear),
      .cnt    (wr_cnt),
      .at_max (wr_max)
   );

   // Drop counter never wraps regardless of SAT_MODE.
   fifo_wr_cnt_ctr #(.W(DROP_W), .SAT(1'b1)) u_drop_ctr (
      .clk    (s00_axi_aclk),
      .rst_n  (s00_axi_aresetn),
      .inc    (dropped),
      .clr    (ctrl_clear),
      .cnt    (drop_cnt),
      .at_max (drop_max)
   );

   // Next-state: clear overrides everything; saturation overflow parks in HOLD.
   always_comb begin
      state_nxt = state;
      if (ctrl_clear)
         state_nxt = ctrl_enable ? ST_RUN : ST_IDLE;
      else begin
         case (state)
            ST_IDLE: if (ctrl_enable) state_nxt = ST_RUN;
            ST_RUN: begin
               if (ovf_ev && SAT)     state_nxt = ST_HOLD;
               else if (!ctrl_enable) state_nxt = ST_IDLE;
            end
            ST_HOLD: state_nxt = ST_HOLD;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) state <= ST_IDLE;
      else                  state <= state_nxt;
   end

   // Sticky flags and the single-cycle irq; clear re-arms the threshold.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         ovf        <= 1'b0;
         thresh_hit <= 1'b0;
         irq        <= 1'b0;
      end else if (ctrl_clear) begin
         ovf        <= 1'b0;
         thresh_hit <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (ovf_ev)   ovf <= 1'b1;
         if (thr_fire) thresh_hit <= 1'b1;
         irq <= thr_fire;
      end
   end

   // Snapshot takes the registered count, before this edge's clear/increment.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn)   snap_cnt <= '0;
      else if (ctrl_snapshot) snap_cnt <= wr_cnt;
   end

   assign status[STAT_OVF]                = ovf;
   assign status[STAT_THR]                = thresh_hit;
   assign status[STAT_ST_HI:STAT_ST_LO]   = state;

endmodule

// File: tb/tb_fifo_wr_cnt_core.sv
// Randomised + directed bench: three configurations share one stimulus
// stream and are each compared every cycle against an arithmetic model.
module tb_fifo_wr_cnt_core;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        wr_en = 1'b0, full = 1'b0, en = 1'b0, clr = 1'b0, snap = 1'b0;
   logic [31:0] thr32 = '0;
   logic [3:0]  thr4  = '0;

   logic [31:0] wr32, snap32;
   logic [15:0] drop32;
   logic [3:0]  st32, wrs4, snaps4, wrw4, snapw4, sts4, stw4;
   logic [2:0]  drops4, dropw4;
   logic        irq32, irqs4, irqw4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_wr_cnt_core #(.CNT_W(32), .DROP_W(16), .SAT_MODE(1)) u_d32 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .fifo_wr_en(wr_en),
      .fifo_full(full), .ctrl_enable(en), .ctrl_clear(clr),
      .ctrl_snapshot(snap), .threshold(thr32), .wr_cnt(wr32),
      .snap_cnt(snap32), .drop_cnt(drop32), .status(st32), .irq(irq32));

   fifo_wr_cnt_core #(.CNT_W(4), .DROP_W(3), .SAT_MODE(1)) u_s4 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .fifo_wr_en(wr_en),
      .fifo_full(full), .ctrl_enable(en), .ctrl_clear(clr),
      .ctrl_snapshot(snap), .threshold(thr4), .wr_cnt(wrs4),
      .snap_cnt(snaps4), .drop_cnt(drops4), .status(sts4), .irq(irqs4));

   fifo_wr_cnt_core #(.CNT_W(4), .DROP_W(3), .SAT_MODE(0)) u_w4 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .fifo_wr_en(wr_en),
      .fifo_full(full), .ctrl_enable(en), .ctrl_clear(clr),
      .ctrl_snapshot(snap), .threshold(thr4), .wr_cnt(wrw4),
      .snap_cnt(snapw4), .drop_cnt(dropw4), .status(stw4), .irq(irqw4));

   // Reference model: 0=IDLE 1=RUN 2=HOLD, counts as plain integers.
   longint m_wr [3], m_drop [3], m_snap [3];
   int     m_st [3];
   bit     m_ovf [3], m_th [3], m_irq [3];
   longint wmax [3] = '{64'hFFFF_FFFF, 15, 15};
   longint dmax [3] = '{65535, 7, 7};
   bit     sat  [3] = '{1'b1, 1'b1, 1'b0};

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_rst();
      for (int i = 0; i < 3; i++) begin
         m_wr[i] = 0; m_drop[i] = 0; m_snap[i] = 0; m_st[i] = 0;
         m_ovf[i] = 0; m_th[i] = 0; m_irq[i] = 0;
      end
   endtask

   task automatic model_step();
      if (!rstn) begin
         model_rst();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         longint thr = (i == 0) ? longint'(thr32) : longint'(thr4);
         longint w   = m_wr[i];
         if (snap) m_snap[i] = w;
         if (clr) begin
            m_wr[i] = 0; m_drop[i] = 0; m_ovf[i] = 0; m_th[i] = 0; m_irq[i] = 0;
            m_st[i] = en ? 1 : 0;
         end else begin
            m_irq[i] = (thr != 0) && (w == thr) && !m_th[i];
            if (m_irq[i]) m_th[i] = 1;
            case (m_st[i])
               0: if (en) m_st[i] = 1;
               1: begin
                  if (wr_en && !full) begin
                     if (w == wmax[i]) begin
                        m_ovf[i] = 1;
                        if (sat[i]) m_st[i] = 2;
                        else        m_wr[i] = 0;
                     end else m_wr[i] = w + 1;
                  end
                  if (wr_en && full && m_drop[i] < dmax[i]) m_drop[i]++;
                  if (m_st[i] == 1 && !en) m_st[i] = 0;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic chk_inst(input int i, input logic [31:0] wr, input logic [31:0] sn,
                           input logic [15:0] dr, input logic [3:0] st, input logic iq);
      logic [3:0] est;
      est = {m_ovf[i], m_th[i], 2'(m_st[i])};
      chk($sformatf("u%0d.wr_cnt", i),   wr, m_wr[i]);
      chk($sformatf("u%0d.snap_cnt", i), sn, m_snap[i]);
      chk($sformatf("u%0d.drop_cnt", i), dr, m_drop[i]);
      chk($sformatf("u%0d.status", i),   st, est);
      chk($sformatf("u%0d.irq", i),      iq, m_irq[i]);
   endtask

   task automatic check_all();
      chk_inst(0, wr32, snap32, drop32, st32, irq32);
      chk_inst(1, 32'(wrs4), 32'(snaps4), 16'(drops4), sts4, irqs4);
      chk_inst(2, 32'(wrw4), 32'(snapw4), 16'(dropw4), stw4, irqw4);
   endtask

   // One clock: model follows the edge, outputs sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic pulse_clear(input logic e);
      en = e; clr = 1'b1; cyc(); clr = 1'b0;
   endtask

   task automatic writes(input int n, input logic f);
      wr_en = 1'b1; full = f;
      repeat (n) cyc();
      wr_en = 1'b0; full = 1'b0;
   endtask

   // Asynchronous reset asserted between edges, held across one rising edge.
   task automatic async_reset();
      rstn = 1'b0;
      #1;
      model_rst();
      check_all();
      cyc();
      rstn = 1'b1;
   endtask

   int irqs, prev_wr;

   initial begin
      model_rst();
      @(negedge clk);
      check_all();
      chk("reset.wr_cnt", wr32, 0);
      chk("reset.status", st32, 0);
      @(negedge clk);
      rstn = 1'b1;

      // Five accepted writes, snapshot, then three writes while full.
      en = 1'b1; cyc();
      writes(5, 1'b0);
      snap = 1'b1; cyc(); snap = 1'b0;
      chk("basic.wr_cnt", wr32, 5);
      chk("basic.snap_cnt", snap32, 5);
      writes(3, 1'b1);
      chk("basic.drop_cnt", drop32, 3);
      chk("basic.wr_hold", wr32, 5);

      // Threshold 4: one irq pulse one edge after the count reaches 4.
      pulse_clear(1'b1);
      thr32 = 32'd4; thr4 = 4'd4;
      irqs = 0; prev_wr = wr32;
      wr_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 6) wr_en = 1'b0;
         cyc();
         if (irq32) begin
            irqs++;
            chk("thr.irq_after_4", prev_wr, 4);
         end
         prev_wr = wr32;
      end
      chk("thr.irq_count", irqs, 1);
      chk("thr.hit", st32[2], 1);
      thr32 = '0; thr4 = '0;

      // 17 writes: 4-bit saturating parks in HOLD, wrapping lands on 1.
      pulse_clear(1'b1);
      writes(17, 1'b0);
      chk("sat.wr_cnt", wrs4, 15);
      chk("sat.status", sts4, 4'b1010);
      chk("wrap.wr_cnt", wrw4, 1);
      chk("wrap.status", stw4, 4'b1001);
      en = 1'b0; cyc(); cyc();
      chk("sat.hold_no_en", sts4[1:0], 2);
      pulse_clear(1'b1);
      chk("sat.clear_run", sts4, 4'b0001);
      chk("sat.clear_cnt", wrs4, 0);

      // Clear + snapshot + accepted write together at count 9.
      pulse_clear(1'b1);
      writes(9, 1'b0);
      clr = 1'b1; snap = 1'b1; wr_en = 1'b1; cyc();
      clr = 1'b0; snap = 1'b0; wr_en = 1'b0;
      chk("combo.snap_cnt", snap32, 9);
      chk("combo.wr_cnt", wr32, 0);

      // Reset mid-RUN at count 7, then writes ignored until enable sampled.
      pulse_clear(1'b1);
      writes(7, 1'b0);
      async_reset();
      chk("arst.wr_cnt", wr32, 0);
      chk("arst.status", st32, 0);
      en = 1'b0;
      writes(3, 1'b0);
      chk("arst.ignored", wr32, 0);
      en = 1'b1;
      writes(3, 1'b0);
      chk("arst.resume", wr32, 2);

      // Random traffic.
      for (int k = 0; k < 1500; k++) begin
         en    = ($urandom % 8) != 0;
         clr   = ($urandom % 40) == 0;
         snap  = ($urandom % 8) == 0;
         wr_en = ($urandom % 2) == 1;
         full  = ($urandom % 4) == 0;
         if ($urandom % 50 == 0) begin
            thr4  = 4'($urandom % 16);
            thr32 = $urandom % 24;
         end
         if ($urandom % 300 == 0) async_reset();
         else cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
